prog_mem_init: RTL and testbench
================================

# prog_mem_init

Parametrised, synchronous, dual-port program/data memory for the accumulator CPU. It replaces the fixed 64x8 combinational program store. Port I is a read-only instruction fetch port. Port D is a read/write data port for operand fetch and stores. After reset, an internal init sequencer writes the boot image into every word, one word per cycle. `ready` stays low until the sequencer finishes.

## Interface
Parameters:
- DATA_W, 8, word width; word = {opcode[OPC_W], operand[DATA_W-OPC_W]}
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
- OPC_W, 2, opcode field width; requires DATA_W-OPC_W >= ADDR_W
- INIT_PROG, 1, 1 = load demo program image, 0 = zero-fill

Ports:
- clk  in  1  clock, all activity on rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once init has completed
- i_en  in  1  instruction read enable
- i_addr  in  ADDR_W  instruction address
- i_data  out  DATA_W  instruction word, registered
- d_en  in  1  data port enable
- d_we  in  1  data write enable (qualified by d_en)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, registered

## Operation
- States: INIT and RUN. rst forces INIT, cnt=0, ready=0, i_data=0, d_rdata=0.
- INIT (rst low): each cycle writes mem[cnt] = img(cnt) and increments cnt.
  - After the write of cnt = DEPTH-1, the next state is RUN and ready=1.
  - The cnt increment is ADDR_W wide. It never wraps back into INIT.
- In INIT, all port inputs are ignored, no user writes occur, and i_data and d_rdata hold 0.
- Boot image, INIT_PROG=1 (operand zero-extended to the operand field):
  - img(0) = {0, DEPTH-1}: add
  - img(1) = {1, DEPTH-2}: and
  - img(2) = {3, 0}: inc
  - img(3) = {2, 2}: jmp 2
  - img(DEPTH-2) = 1<<(DATA_W-3)
  - img(DEPTH-1) = {0, DEPTH-1}
  - every other word = 0
- Boot image, INIT_PROG=0: all words 0.
- RUN, port I: if i_en, then i_data <= mem[i_addr]; otherwise i_data holds its value.
- RUN, port D:
  - d_en & d_we: mem[d_addr] <= d_wdata, and d_rdata <= d_wdata (write-first).
  - d_en & !d_we: d_rdata <= mem[d_addr].
  - !d_en: d_rdata holds its value and memory is unchanged.
- Collision, port D write and port I read at the same address in the same cycle: i_data returns the OLD word (read-first). The new word is visible to port I from the next cycle.
- rst asserted in RUN: return to INIT. The full image is rewritten, so all prior user writes are lost.
- rst asserted during INIT: cnt restarts at 0.

## Timing
- Read latency is 1 cycle on both ports: address sampled at edge N, data valid after edge N.
- Init duration:
  - rst sampled high at edge R, rst low from edge R+1.
  - Image words are written at edges R+1 .. R+DEPTH.
  - ready is high after edge R+DEPTH, i.e. DEPTH cycles after rst is released.
- ready is level: once high, it stays high until the next rst.
- The first user access is sampled at the first edge where ready is already high.
  - An access presented in the same cycle that ready rises is ignored.
- Reset values:
  - ready = 0, i_data = 0, d_rdata = 0.
  - Memory contents are undefined until rewritten by INIT.

## Test plan
- Reset then wait; default params: ready low for exactly 64 cycles after rst falls, then high. Then i_addr = 0,1,2,3,62,63,10 return 0x3F, 0x7E, 0xC0, 0x82, 0x20, 0x3F, 0x00, each one cycle after the address is sampled.
- Write then read on port D: write 0x5A to addr 40. d_rdata = 0x5A in the same cycle (write-first). Next cycle, i_addr = 40 reads 0x5A, and d_en=0 holds d_rdata at 0x5A.
- Collision: old mem[5] = 0x00; port D writes 0xA5 to addr 5 while i_addr = 5, i_en = 1. i_data = 0x00, then 0xA5 on the following i_en read.
- Ignored during init: drive d_en = d_we = 1, d_addr = 0, d_wdata = 0xFF during INIT. After ready, addr 0 reads 0x3F and d_rdata stays 0 throughout INIT.
- Reset mid-run: overwrite addr 0 with 0x11, assert rst for 1 cycle. ready drops, returns after 64 cycles, and addr 0 reads 0x3F again.
- Parameter sweep:
  - DATA_W=10, ADDR_W=7, OPC_W=2: ready after 128 cycles; img(0) = 0x07F, img(3) = 0x202, img(126) = 0x080.
  - INIT_PROG=0: all 64 addresses read 0.

Source files
------------

// File: rtl/prog_mem_init.sv
// Dual-port program/data memory for the accumulator CPU.
// After reset a sequencer writes the boot image one word per cycle; ready rises when it is done.
module prog_mem_init #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned OPC_W     = 2,
    parameter int unsigned INIT_PROG = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    input  logic              d_en,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned OPND_W = DATA_W - OPC_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              run;

    logic [DATA_W-1:0] mem [DEPTH];

    // Demo program: add/and against the two top words, then an inc/jmp loop.
    function automatic logic [DATA_W-1:0] img_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        if (INIT_PROG != 0) begin
            if (a == ADDR_W'(0)) begin
                w = {OPC_W'(0), OPND_W'(DEPTH - 1)};
            end else if (a == ADDR_W'(1)) begin
                w = {OPC_W'(1), OPND_W'(DEPTH - 2)};
            end else if (a == ADDR_W'(2)) begin
                w = {OPC_W'(3), OPND_W'(0)};
            end else if (a == ADDR_W'(3)) begin
                w = {OPC_W'(2), OPND_W'(2)};
            end else if (a == ADDR_W'(DEPTH - 2)) begin
                w = DATA_W'(1) << (DATA_W - 3);
            end else if (a == LastAddr) begin
                w = {OPC_W'(0), OPND_W'(DEPTH - 1)};
            end
        end
        return w;
    endfunction

    assign run   = (state_q == StRun);
    assign ready = run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = d_addr;
        mem_wdata = d_wdata;
        unique case (state_q)
            StInit: begin
                mem_we    = !rst;
                mem_waddr = cnt_q;
                mem_wdata = img_word(cnt_q);
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we = !rst && d_en && d_we;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Port I reads the pre-write word on a same-address collision (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            i_data <= '0;
        end else if (run && i_en) begin
            i_data <= mem[i_addr];
        end
    end

    // Port D returns the written word on a write (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_rdata <= '0;
        end else if (run && d_en) begin
            d_rdata <= d_we ? d_wdata : mem[d_addr];
        end
    end

endmodule

// File: tb/tb_prog_mem_init.sv
// Directed and randomized checks of prog_mem_init against a behavioural memory model.
module tb_prog_mem_init;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       ready, i_en, d_en, d_we;
    logic [5:0] i_addr, d_addr;
    logic [7:0] i_data, d_wdata, d_rdata;

    logic       ready_w;
    logic [6:0] iw_addr;
    logic [9:0] iw_data, dw_rdata;

    logic       ready_z;
    logic [5:0] iz_addr;
    logic [7:0] iz_data, dz_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] model [64];
    logic [7:0] exp_i, exp_d;

    always #5 clk = ~clk;

    prog_mem_init dut (
        .clk(clk), .rst(rst), .ready(ready),
        .i_en(i_en), .i_addr(i_addr), .i_data(i_data),
        .d_en(d_en), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    prog_mem_init #(.DATA_W(10), .ADDR_W(7), .OPC_W(2), .INIT_PROG(1)) dut_w (
        .clk(clk), .rst(rst), .ready(ready_w),
        .i_en(1'b1), .i_addr(iw_addr), .i_data(iw_data),
        .d_en(1'b0), .d_we(1'b0), .d_addr(7'd0), .d_wdata(10'd0), .d_rdata(dw_rdata)
    );

    prog_mem_init #(.INIT_PROG(0)) dut_z (
        .clk(clk), .rst(rst), .ready(ready_z),
        .i_en(1'b1), .i_addr(iz_addr), .i_data(iz_data),
        .d_en(1'b0), .d_we(1'b0), .d_addr(6'd0), .d_wdata(8'd0), .d_rdata(dz_rdata)
    );

    // Boot image from the word-level rules, as plain integers.
    function automatic int ref_img(int a, int dw, int aw, int ow);
        int depth = 1 << aw;
        int ob = 1 << (dw - ow);
        if (a == 0) return depth - 1;
        if (a == 1) return ob + depth - 2;
        if (a == 2) return 3 * ob;
        if (a == 3) return 2 * ob + 2;
        if (a == depth - 2) return 1 << (dw - 3);
        if (a == depth - 1) return depth - 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_i(input logic [5:0] a, input logic [7:0] expv, input string tag);
        i_addr = a;
        i_en   = 1'b1;
        step();
        check(tag, 32'(i_data), 32'(expv));
        i_en = 1'b0;
    endtask

    initial begin
        i_en = 0; d_en = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
        iw_addr = 0; iz_addr = 0;
        for (int a = 0; a < 64; a++) model[a] = 8'(ref_img(a, 8, 6, 2));

        rst = 1'b1;
        step();
        step();
        check("rst_ready", 32'(ready), 0);
        check("rst_i_data", 32'(i_data), 0);
        check("rst_d_rdata", 32'(d_rdata), 0);

        // Init: user traffic present the whole time must be ignored.
        rst = 1'b0;
        d_en = 1; d_we = 1; d_addr = 0; d_wdata = 8'hFF; i_en = 1; i_addr = 0;
        for (int k = 1; k <= 128; k++) begin
            step();
            check("init_ready", 32'(ready), 32'(k >= 64));
            check("init_ready_w", 32'(ready_w), 32'(k >= 128));
            check("init_ready_z", 32'(ready_z), 32'(k >= 64));
            if (k <= 64) begin
                check("init_d_rdata", 32'(d_rdata), 0);
                check("init_i_data", 32'(i_data), 0);
            end
            if (k == 64) begin
                d_en = 0; d_we = 0; i_en = 0;
            end
        end
        check("w_d_rdata", 32'(dw_rdata), 0);
        check("z_d_rdata", 32'(dz_rdata), 0);

        read_i(6'd0, 8'h3F, "img0");
        read_i(6'd1, 8'h7E, "img1");
        read_i(6'd2, 8'hC0, "img2");
        read_i(6'd3, 8'h82, "img3");
        read_i(6'd62, 8'h20, "img62");
        read_i(6'd63, 8'h3F, "img63");
        read_i(6'd10, 8'h00, "img10");

        iw_addr = 7'd0;   step(); check("w_img0", 32'(iw_data), 32'h07F);
        iw_addr = 7'd3;   step(); check("w_img3", 32'(iw_data), 32'h202);
        iw_addr = 7'd126; step(); check("w_img126", 32'(iw_data), 32'h080);
        iw_addr = 7'd1;   step(); check("w_img1", 32'(iw_data), 32'(ref_img(1, 10, 7, 2)));

        for (int a = 0; a < 64; a++) begin
            iz_addr = 6'(a);
            step();
            check("zero_fill", 32'(iz_data), 0);
        end

        // Write-first on port D, then visible on port I.
        d_en = 1; d_we = 1; d_addr = 6'd40; d_wdata = 8'h5A;
        step();
        check("wr_first", 32'(d_rdata), 32'h5A);
        model[40] = 8'h5A;
        d_en = 0; d_we = 0; d_wdata = 8'h00;
        read_i(6'd40, 8'h5A, "wr_then_i");
        check("d_hold", 32'(d_rdata), 32'h5A);

        // Collision: port I gets the old word.
        d_en = 1; d_we = 1; d_addr = 6'd5; d_wdata = 8'hA5; i_addr = 6'd5; i_en = 1;
        step();
        check("coll_old", 32'(i_data), 32'(model[5]));
        model[5] = 8'hA5;
        d_en = 0; d_we = 0;
        step();
        check("coll_new", 32'(i_data), 32'hA5);
        i_en = 0;

        // Reset mid-run wipes user writes.
        d_en = 1; d_we = 1; d_addr = 6'd0; d_wdata = 8'h11;
        step();
        check("ovw_d", 32'(d_rdata), 32'h11);
        d_en = 0; d_we = 0;
        read_i(6'd0, 8'h11, "ovw_i");
        rst = 1'b1;
        step();
        check("rr_ready", 32'(ready), 0);
        check("rr_i_data", 32'(i_data), 0);
        check("rr_d_rdata", 32'(d_rdata), 0);
        rst = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            check("rr_init_ready", 32'(ready), 32'(k == 64));
        end
        for (int a = 0; a < 64; a++) model[a] = 8'(ref_img(a, 8, 6, 2));
        read_i(6'd0, 8'h3F, "rr_img0");
        read_i(6'd40, 8'h00, "rr_img40");

        // Random traffic against the array model.
        exp_i = 8'h00;
        exp_d = 8'h00;
        for (int n = 0; n < 400; n++) begin
            i_en    = 1'($urandom);
            i_addr  = 6'($urandom);
            d_en    = 1'($urandom);
            d_we    = 1'($urandom);
            d_addr  = ($urandom_range(0, 3) == 0) ? i_addr : 6'($urandom);
            d_wdata = 8'($urandom);
            if (i_en) exp_i = model[i_addr];
            if (d_en) exp_d = d_we ? d_wdata : model[d_addr];
            if (d_en && d_we) model[d_addr] = d_wdata;
            step();
            check("rnd_i_data", 32'(i_data), 32'(exp_i));
            check("rnd_d_rdata", 32'(d_rdata), 32'(exp_d));
        end
        check("rnd_ready", 32'(ready), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
